// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, reads sync imem, presents instr/pc/pc+4 to decode.
// Latency: 2 cycles from reset release or 3 cycles from a redirect edge to instr_valid; 1 instr per 2 cycles sustained.
// Backpressure: instr_ready=0 holds VALID with outputs frozen and no imem read; redirect always wins.
// Optional misaligned-target trap: define FETCH_MISALIGN_TRAP_EN (default build forces target[1:0]=0).
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 11
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_rden,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic [31:0]        instr_pc,
  output logic [31:0]        instr_pc4,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_target,
  output logic               fault,
  output logic [31:0]        fault_pc
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2, S_FAULT = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_REQ = 2'd0, S_WAIT = 2'd1, S_VALID = 2'd2} state_t;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [31:0]        r_pc;
  logic [31:0]        w_pc_nxt;
  logic [31:0]        w_pc_inc;
  logic [31:0]        w_target;
  logic               w_redir;
  logic               w_capture;
  logic               w_rden;
  logic [IMEM_AW-1:0] w_rd_addr;
  logic [31:0]        r_instr;
  logic [31:0]        r_instr_pc;
  logic               r_instr_valid;

  assign w_pc_inc = r_pc + 32'd4;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic        w_misalign;
  logic        r_fault;
  logic [31:0] r_fault_pc;

  // Once faulted the unit is frozen; redirects are ignored until reset.
  assign w_redir    = redirect_valid && (r_state != S_FAULT);
  assign w_target   = redirect_target;
  assign w_misalign = |redirect_target[1:0];
`else
  assign w_redir  = redirect_valid;
  assign w_target = redirect_target & ~32'h0000_0003;
`endif

  // Next state, next PC and the combinational imem read strobe/address.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_rden      = 1'b0;
    w_rd_addr   = r_pc[IMEM_AW+1:2];
    w_capture   = 1'b0;
    case (r_state)
      S_REQ: begin
        w_rden      = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        w_capture   = 1'b1;
        w_state_nxt = S_VALID;
      end
      S_VALID: begin
        // Accepted handshake: launch the next sequential read in the same cycle.
        if (instr_ready) begin
          w_rden      = 1'b1;
          w_rd_addr   = w_pc_inc[IMEM_AW+1:2];
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = S_WAIT;
        end
      end
      default: begin
`ifdef FETCH_MISALIGN_TRAP_EN
        w_state_nxt = r_state;
`else
        w_state_nxt = S_REQ;
`endif
      end
    endcase
    // Redirect overrides everything: kill the read, drop any in-flight data.
    if (w_redir) begin
      w_rden      = 1'b0;
      w_capture   = 1'b0;
      w_pc_nxt    = w_target;
      w_state_nxt = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      if (w_misalign) begin
        w_pc_nxt    = r_pc;
        w_state_nxt = S_FAULT;
      end
`endif
    end
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
    end
  end

  // Instruction buffer: loaded from imem in WAIT, valid exactly while in VALID.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_instr       <= NOP;
      r_instr_pc    <= RESET_PC;
      r_instr_valid <= 1'b0;
    end else begin
      r_instr_valid <= (w_state_nxt == S_VALID);
      if (w_capture) begin
        r_instr    <= imem_rdata;
        r_instr_pc <= r_pc;
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky fault flag and the offending redirect target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fault    <= 1'b0;
      r_fault_pc <= 32'h0;
    end else if (w_redir && w_misalign) begin
      r_fault    <= 1'b1;
      r_fault_pc <= redirect_target;
    end
  end

  assign fault    = r_fault;
  assign fault_pc = r_fault_pc;
`else
  assign fault    = 1'b0;
  assign fault_pc = 32'h0;
`endif

  assign imem_rden   = w_rden;
  assign imem_addr   = w_rd_addr;
  assign instr_valid = r_instr_valid;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_pc4   = r_instr_pc + 32'd4;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the single-cycle-issue RV32I core. It owns the program counter and reads the synchronous instruction memory. It presents each instruction, with its PC and PC+4, to decode over a valid/ready handshake. It accepts redirects (JAL and taken branches) from execute. Every redirect discards the fetch in flight and restarts fetching at the target.

## Interface
- `RESET_PC`, 32'h0000_0000, PC loaded on reset.
- `IMEM_AW`, 11, instruction-memory word-address width (2^11 words = 8 KiB).

- `clk`  in  1  core clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `imem_rden`  out  1  read strobe to instruction BRAM.
- `imem_addr`  out  IMEM_AW  word address, equal to the read PC[IMEM_AW+1:2].
- `imem_rdata`  in  32  read data, valid exactly one cycle after `imem_rden`.
- `instr_valid`  out  1  buffered instruction available to decode.
- `instr_ready`  in  1  decode accepts the instruction this cycle.
- `instr`  out  32  instruction word.
- `instr_pc`  out  32  PC of `instr`.
- `instr_pc4`  out  32  `instr_pc` + 4; this is the JAL/JALR link value.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_target`  in  32  new PC.
- `fault`  out  1  sticky misaligned-target flag.
- `fault_pc`  out  32  offending target.

## Operation
- States: REQ, WAIT, VALID, and FAULT (FAULT is present only with the macro).
- REQ:
  - `imem_rden`=1 and `imem_addr`=pc.
  - Next state is WAIT.
- WAIT:
  - Capture `imem_rdata` into the instruction buffer.
  - Set `instr_pc`=pc.
  - Next state is VALID.
- VALID:
  - `instr_valid`=1.
  - If `instr_ready`=1: pc←pc+4, and in the same cycle `imem_rden`=1 with `imem_addr`=pc+4. Next state is WAIT.
  - Otherwise hold all outputs unchanged.
- Redirect has the highest priority in every state except FAULT:
  - pc←target and next state is REQ.
  - `imem_rden`=0 in that cycle.
  - Data arriving in a WAIT state that was entered before the redirect is never presented.
- Redirect coincident with an accepted handshake (`instr_valid`&`instr_ready`): the handshake counts as consumed, since it is the jump itself. The redirect wins, and pc+4 is not fetched.
- Arithmetic:
  - pc+4 is computed modulo 2^32; 32'hFFFF_FFFC wraps to 0.
  - `imem_addr` takes the low bits only, so addresses beyond the memory alias.
- `instr_pc4` is combinational from `instr_pc` and computed modulo 2^32.
- Reset values:
  - pc=`RESET_PC`, state=REQ.
  - `instr_valid`=0, `instr`=32'h0000_0013 (NOP), `instr_pc`=`RESET_PC`.
  - `fault`=0, `fault_pc`=0.
  - `imem_rden` follows state, so it is 1 in the first cycle after reset release.
- Reset asserted mid-fetch: state is forced immediately and asynchronously. The pending read data is ignored.

## Timing
- Reset release to first `instr_valid`=1: 2 cycles (REQ, WAIT).
- Sustained throughput with `instr_ready` tied 1: one instruction per 2 cycles (VALID→WAIT→VALID).
- Redirect latency: the redirect is sampled at edge N. `imem_rden` with the target address is driven in cycle N+1. `instr_valid` for the target is 1 in cycle N+3.
- `instr_valid` falls in the cycle after a redirect edge. It never shows stale data.
- `instr`, `instr_pc` and `instr_valid` are registered.
- `imem_rden` and `imem_addr` are combinational from state, pc and `instr_ready`.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with target[1:0]≠0 enters FAULT.
  - It sets `fault`=1 and `fault_pc`=target.
  - `instr_valid`=0 and `imem_rden`=0.
  - Further redirects are ignored until reset.
- Not defined:
  - target[1:0] is forced to 2'b00.
  - `fault` and `fault_pc` are tied to 0.
  - No FAULT state exists.

## Test plan
- Release reset with `RESET_PC`=0, `instr_ready`=1, memory holding 0x00500093 at word 0 → `instr_valid` rises 2 cycles later with `instr`=0x00500093, `instr_pc`=0, `instr_pc4`=4.
- Sequential fetch of 4 words with `instr_ready` held 1 → `instr_pc` takes the values 0, 4, 8, 12 on alternate cycles. `imem_addr` takes 0, 1, 2, 3.
- Hold `instr_ready`=0 for 5 cycles in VALID → `instr` and `instr_pc` stay stable, and `imem_rden`=0 throughout.
- Redirect to 0x20 issued during WAIT of pc 0x8 → the word at 0x8 is never presented. The next valid has `instr_pc`=0x20 and `instr_pc4`=0x24, 3 cycles after the redirect edge.
- Redirect to 0x1E:
  - With `FETCH_MISALIGN_TRAP_EN` → `fault`=1, `fault_pc`=0x1E, and no further fetches until reset.
  - Without it → fetch resumes at 0x1C.
- Assert reset (0) in the middle of WAIT → `instr_valid` goes to 0 and pc to `RESET_PC` without a clock edge. On release, the fetch restarts at `RESET_PC`.
